// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer
//   Multi-cycle wide adder/subtractor. A single 4-bit parallel_adder is
//   time-shared across a 4*WORDS-bit operand pair, one nibble per clock,
//   least-significant nibble first. The ripple carry is held in a register
//   between nibbles.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request; sampled only in IDLE or DONE
//   sub    in   0 = a+b+cin, 1 = a-b (two's complement)
//   a, b   in   W-bit operands, latched on accept
//   cin    in   carry-in for add; ignored when sub=1
//   busy   out  high while in RUN
//   done   out  one-cycle pulse, result valid
//   sum    out  W-bit result register
//   cout   out  final carry (for subtract, 1 = no borrow)
//   ovf    out  signed overflow of the W-bit result

// 4-bit ripple adder shared by the sequencer.
module parallel_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | processing nibble idx, one per clock
// DONE  | result valid, done pulse; may accept a new start
module nibble_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*WORDS-1:0]   a,
  input  logic [4*WORDS-1:0]   b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W     = 4 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] add_a, add_b, add_sum;
  logic       add_cout;

  // Nibble select from the latched operands; b is inverted for subtract,
  // and the +1 comes from carry_q being preloaded to 1.
  always_comb begin
    add_a = 4'h0;
    add_b = 4'h0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        add_a = a_q[4*k +: 4];
        add_b = b_q[4*k +: 4];
      end
    end
    if (sub_q) add_b = add_b ^ 4'hF;
  end

  parallel_adder u_adder (add_a, add_b, carry_q, add_sum, add_cout);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int k = 0; k < WORDS; k++) begin
          if (idx_q == IDX_W'(k)) sum_d[4*k +: 4] = add_sum;
        end
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          cout_d  = add_cout;
          // Top bit of the result is bit 3 of the final nibble's sum.
          ovf_d   = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (add_sum[3] != a_q[W-1]);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed testbench for nibble_add_sequencer with WORDS=4 (16-bit).
module tb_nibble_add_sequencer;
  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  nibble_add_sequencer #(.WORDS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Issue one request and wait for done (bounded). Reports edges from
  // accept to done and number of sampled cycles with busy high.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                        input logic tc, output int lat, output int busy_n);
    a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    int lat, bn;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_init busy=%b done=%b sum=%h cout=%b ovf=%b want all 0", busy, done, sum, cout, ovf);
    end
    a = 16'h1111; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (busy !== 1'b1 || sum !== 16'h0022) begin
      bad++;
      $display("FAIL reset_midrun_pre busy=%b sum=%h want busy=1 sum=0022", busy, sum);
    end
    #2 rst = 1'b1; #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_async busy=%b done=%b sum=%h cout=%b ovf=%b want all 0", busy, done, sum, cout, ovf);
    end
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_done done=%b busy=%b want 0 0", done, busy);
    end
    rst = 1'b0;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat, bn);
    total++;
    if (lat !== 4 || sum !== 16'h0002) begin
      bad++;
      $display("FAIL reset_after lat=%0d sum=%h want lat=4 sum=0002", lat, sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add;
    int lat, bn;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, bn);
    total++;
    if (lat !== 4 || bn !== 4) begin
      bad++;
      $display("FAIL add_timing lat=%0d busy_cycles=%0d want 4 4", lat, bn);
    end
    total++;
    if (sum !== 16'h5555 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL add_result sum=%h cout=%b ovf=%b want 5555 0 0", sum, cout, ovf);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL add_done_pulse done=%b want 0", done);
    end
  endtask

  task automatic test_full_ripple;
    int lat, bn;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bn);
    total++;
    if (lat !== 4 || sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL ripple_carry lat=%0d sum=%h cout=%b ovf=%b want 4 0000 1 0", lat, sum, cout, ovf);
    end
    @(posedge clk); #1;
    run_op(16'h7FFF, 16'h0000, 1'b0, 1'b1, lat, bn);
    total++;
    if (lat !== 4 || sum !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL ripple_cin_ovf lat=%0d sum=%h cout=%b ovf=%b want 4 8000 0 1", lat, sum, cout, ovf);
    end
    @(posedge clk); #1;
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b1, lat, bn);
    total++;
    if (sum !== 16'h1001 || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL ripple_mid sum=%h cout=%b ovf=%b want 1001 0 0", sum, cout, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_subtract;
    int lat, bn;
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat, bn);
    total++;
    if (lat !== 4 || sum !== 16'hFFFE || cout !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL sub_borrow lat=%0d sum=%h cout=%b ovf=%b want 4 fffe 0 0", lat, sum, cout, ovf);
    end
    @(posedge clk); #1;
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, lat, bn);
    total++;
    if (sum !== 16'h7FFF || cout !== 1'b1 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL sub_ovf sum=%h cout=%b ovf=%b want 7fff 1 1", sum, cout, ovf);
    end
    @(posedge clk); #1;
    run_op(16'h1234, 16'h1234, 1'b1, 1'b0, lat, bn);
    total++;
    if (sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL sub_equal sum=%h cout=%b ovf=%b want 0000 1 0", sum, cout, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_handshake;
    int n, c1, c2;
    a = 16'h1000; b = 16'h0234; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (done !== 1'b1 || n !== 2 || sum !== 16'h1234) begin
      bad++;
      $display("FAIL hs_ignore done=%b wait=%0d sum=%h want 1 2 1234", done, n, sum);
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL hs_ignore_idle busy=%b done=%b want 0 0", busy, done);
    end

    a = 16'h1111; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h00FF; b = 16'h0001;
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    c1 = cyc;
    total++;
    if (done !== 1'b1 || sum !== 16'h2222) begin
      bad++;
      $display("FAIL b2b_first done=%b sum=%h want 1 2222", done, sum);
    end
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_reaccept busy=%b done=%b want 1 0", busy, done);
    end
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    c2 = cyc;
    total++;
    if (done !== 1'b1 || (c2 - c1) !== 5 || sum !== 16'h0100) begin
      bad++;
      $display("FAIL b2b_second done=%b gap=%0d sum=%h want 1 5 0100", done, c2 - c1, sum);
    end
  endtask

  task automatic test_hold;
    logic [15:0] s0;
    logic        c0, o0;
    int lat, bn;
    run_op(16'h7000, 16'h7000, 1'b0, 1'b0, lat, bn);
    s0 = 16'hE000; c0 = 1'b0; o0 = 1'b1;
    total++;
    if (sum !== s0 || cout !== c0 || ovf !== o0) begin
      bad++;
      $display("FAIL hold_setup sum=%h cout=%b ovf=%b want e000 0 1", sum, cout, ovf);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if (sum !== s0 || cout !== c0 || ovf !== o0 || done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d sum=%h cout=%b ovf=%b done=%b busy=%b want e000 0 1 0 0",
                 i, sum, cout, ovf, done, busy);
      end
    end
    a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL hold_clear sum=%h cout=%b ovf=%b busy=%b want 0000 0 0 1", sum, cout, ovf, busy);
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset_entry();
    test_basic_add();
    test_full_ripple();
    test_subtract();
    test_handshake();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Checks reset values while rst is still asserted, then releases it and
  // runs the mid-run reset scenario.
  task automatic test_reset_entry;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0) begin
      bad++;
      $display("FAIL reset_held busy=%b done=%b sum=%h want 0 0 0000", busy, done, sum);
    end
    rst = 1'b0;
    test_reset();
  endtask

endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Multi-cycle wide adder/subtractor controller that time-shares a single `parallel_adder` (4-bit a, b, cin → sum, cout) across a `4*WORDS`-bit operand pair.
- Processing is least-significant nibble first, one nibble per clock.
- The ripple carry is held in a register between nibbles.
- It sits between a requester issuing start/operands and the shared 4-bit adder datapath, and returns a registered wide result with a one-cycle done pulse.

## Interface
- `WORDS`, default 4: number of 4-bit nibbles; operand width `W = 4*WORDS`; legal range 2..16.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high; the only clock is `clk`.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `sub`  in  1  0 = a+b+cin, 1 = a−b (two's complement); latched with start.
- `a`  in  W  operand A; latched with start.
- `b`  in  W  operand B; latched with start.
- `cin`  in  1  carry-in for add; ignored when `sub=1`; latched with start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse, result valid.
- `sum`  out  W  result register.
- `cout`  out  1  final carry; for subtract, 1 = no borrow.
- `ovf`  out  1  signed overflow of the W-bit result.

## Operation
- Instantiates exactly one `parallel_adder`, connected positionally (a, b, cin, sum, cout).
- Adder inputs are driven combinationally from the latched operands:
  - a-side = `a_q[4*idx+:4]`
  - b-side = `b_q[4*idx+:4]`, XOR 4'hF when `sub_q`
  - carry-in = `carry_q`
- State machine `IDLE`, `RUN`, `DONE`:
  - IDLE, `start=1` → RUN. Latch `a`, `b`, `sub`; `carry_q ← sub ? 1 : cin`; `idx ← 0`; clear `sum`, `cout`, `ovf` to 0.
  - IDLE, `start=0` → stay IDLE.
  - RUN, each edge: `sum[4*idx+:4] ← adder sum`; `carry_q ← adder cout`; `idx ← idx+1`.
  - RUN, on the edge where `idx==WORDS-1`: also `cout ← adder cout`, `ovf ←` the overflow expression below, then → DONE.
  - DONE: `done=1` for this cycle only.
    - `start=1` → accept as from IDLE, go to RUN.
    - `start=0` → IDLE.
- `start` while RUN is ignored; latched operands do not change mid-operation.
- `ovf = (a_q[W-1] == b_eff[W-1]) && (result[W-1] != a_q[W-1])`, where `b_eff` = `b_q` inverted when `sub_q`. It is computed from the final nibble's adder sum bit 3.
- `idx` width is `$clog2(WORDS)`. There is no wrap: `idx` is don't-care outside RUN and is reloaded to 0 on accept.
- `sum`, `cout` and `ovf` hold their value after DONE until the next accepted start clears them.

## Timing
- Reset (async assert, any state): state IDLE, `busy=0`, `done=0`, `sum=0`, `cout=0`, `ovf=0`, `carry_q=0`, `idx=0`.
- Reset asserted mid-RUN aborts the operation and produces no done. First accept is possible on the first edge after deassertion.
- Start accepted at edge T:
  - `busy` is high from after T until after edge T+WORDS.
  - Nibble k is written at edge T+1+k.
  - `done` is high for exactly the cycle between edges T+WORDS and T+WORDS+1.
- Latency is WORDS edges from accept to done.
- `start` held high continuously gives back-to-back operations with period WORDS+1 edges.
- Partially written `sum` is visible while `busy=1`; it is valid only when `done=1` or afterwards.
- No combinational path from any input to any output.

## Test plan
Use WORDS=4 (W=16).
- **Reset:** assert `rst` mid-RUN → all outputs 0 immediately (before the next clock edge), state IDLE. After release, `start` with a=0x0001, b=0x0001 → done after 4 edges, sum=0x0002.
- **Basic add:** a=0x1234, b=0x4321, sub=0, cin=0 → done exactly 4 edges after accept; sum=0x5555, cout=0, ovf=0; `busy` high 4 cycles.
- **Full ripple:** a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Separately, a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
- **Subtract:** a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0. Separately, a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- **Handshake:** pulse `start` with new operands during RUN → ignored, result matches the first operands. Hold `start` high across two operations (0x1111+0x1111, then 0x00FF+0x0001) → done pulses 5 edges apart, sums 0x2222 then 0x0100.
- **Hold:** after done with `start` low for 10 cycles → `sum`/`cout`/`ovf` unchanged, `done` and `busy` stay 0.
